// File: rtl/host_mailbox.sv
// Multi-channel host<->kernel mailbox: per-channel command FIFO (host write -> kernel stream)
// and response FIFO (kernel stream -> host read-pop), with host-visible status and sticky errors.
module host_mailbox #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 host_en,
  input  logic [3:0]           host_we,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [DATA_W-1:0]    host_din,
  output logic [DATA_W-1:0]    host_dout,
  input  logic                 host_rst,
  output logic [NUM_CH-1:0]    cmd_valid,
  output logic [NUM_CH*32-1:0] cmd_data,
  input  logic [NUM_CH-1:0]    cmd_ready,
  input  logic [NUM_CH-1:0]    rsp_valid,
  input  logic [NUM_CH*32-1:0] rsp_data,
  output logic [NUM_CH-1:0]    rsp_ready
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CHW = ADDR_W - 4;

  logic [CHW-1:0]              w_ch;
  logic [1:0]                  w_reg;
  logic                        w_wr;
  logic                        w_rd;
  logic [NUM_CH-1:0][31:0]     w_status;
  logic [NUM_CH-1:0][31:0]     w_rsp_head;
  logic [31:0]                 w_rd_data;
  logic [31:0]                 r_host_dout;
  logic                        w_unused_addr;

  assign w_ch          = host_addr[ADDR_W-1:4];
  assign w_reg         = host_addr[3:2];
  assign w_wr          = host_en && (host_we != 4'h0);
  assign w_rd          = host_en && (host_we == 4'h0);
  assign w_unused_addr = &host_addr[1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [31:0]   r_cmd_mem [DEPTH];
    logic [31:0]   r_rsp_mem [DEPTH];
    logic [PW-1:0] r_cmd_wp, r_cmd_rp, r_rsp_wp, r_rsp_rp;
    logic [CW-1:0] r_cmd_cnt, r_rsp_cnt;
    logic          r_ovf, r_udf;
    logic          w_sel, w_cmd_req, w_cmd_full, w_cmd_pop, w_cmd_push, w_ovf_set;
    logic          w_rsp_push, w_rsp_req, w_rsp_empty, w_rsp_pop, w_udf_set, w_w1c;

    assign w_sel       = (w_ch == CHW'(c));
    assign w_cmd_req   = w_wr && w_sel && (w_reg == 2'd0) && (host_we == 4'hF);
    assign w_cmd_full  = (r_cmd_cnt == CW'(DEPTH));
    assign w_cmd_pop   = cmd_valid[c] && cmd_ready[c];
    // A full FIFO still accepts a push when the kernel frees a slot in the same cycle.
    assign w_cmd_push  = w_cmd_req && (!w_cmd_full || w_cmd_pop);
    assign w_ovf_set   = w_cmd_req && w_cmd_full && !w_cmd_pop;
    assign w_rsp_push  = rsp_valid[c] && rsp_ready[c];
    assign w_rsp_req   = w_rd && w_sel && (w_reg == 2'd2);
    assign w_rsp_empty = (r_rsp_cnt == '0);
    assign w_rsp_pop   = w_rsp_req && !w_rsp_empty;
    assign w_udf_set   = w_rsp_req && w_rsp_empty;
    assign w_w1c       = w_wr && w_sel && (w_reg == 2'd1) && host_we[2];

    assign cmd_valid[c]         = (r_cmd_cnt != '0);
    assign cmd_data[32*c +: 32] = r_cmd_mem[r_cmd_rp];
    assign rsp_ready[c]         = (r_rsp_cnt != CW'(DEPTH));
    assign w_status[c]          = {14'd0, r_udf, r_ovf, 8'(r_rsp_cnt), 8'(r_cmd_cnt)};
    assign w_rsp_head[c]        = w_rsp_empty ? 32'd0 : r_rsp_mem[r_rsp_rp];

    // NOTE: storage has no reset; emptiness is defined by the pointers/counts alone.
    always_ff @(posedge clk) begin
      if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= host_din;
      if (w_rsp_push) r_rsp_mem[r_rsp_wp] <= rsp_data[32*c +: 32];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_cmd_wp  <= '0;
        r_cmd_rp  <= '0;
        r_cmd_cnt <= '0;
        r_rsp_wp  <= '0;
        r_rsp_rp  <= '0;
        r_rsp_cnt <= '0;
        r_ovf     <= 1'b0;
        r_udf     <= 1'b0;
      end else if (host_rst) begin
        r_cmd_wp  <= '0;
        r_cmd_rp  <= '0;
        r_cmd_cnt <= '0;
        r_rsp_wp  <= '0;
        r_rsp_rp  <= '0;
        r_rsp_cnt <= '0;
        r_ovf     <= 1'b0;
        r_udf     <= 1'b0;
      end else begin
        if (w_cmd_push) r_cmd_wp <= r_cmd_wp + 1'b1;
        if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + 1'b1;
        r_cmd_cnt <= r_cmd_cnt + CW'(w_cmd_push) - CW'(w_cmd_pop);
        if (w_rsp_push) r_rsp_wp <= r_rsp_wp + 1'b1;
        if (w_rsp_pop)  r_rsp_rp <= r_rsp_rp + 1'b1;
        r_rsp_cnt <= r_rsp_cnt + CW'(w_rsp_push) - CW'(w_rsp_pop);
        // Set has priority over a simultaneous write-1-to-clear.
        if (w_ovf_set)                  r_ovf <= 1'b1;
        else if (w_w1c && host_din[16]) r_ovf <= 1'b0;
        if (w_udf_set)                  r_udf <= 1'b1;
        else if (w_w1c && host_din[17]) r_udf <= 1'b0;
      end
    end
  end

  // NOTE: default assigned first so the read mux cannot infer a latch.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == CHW'(i)) begin
        case (w_reg)
          2'd1:    w_rd_data = w_status[i];
          2'd2:    w_rd_data = w_rsp_head[i];
          default: w_rd_data = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_host_dout <= '0;
    else if (host_rst) r_host_dout <= '0;
    else if (w_rd)     r_host_dout <= w_rd_data;
  end

  assign host_dout = r_host_dout;

endmodule

// File: tb/tb_host_mailbox.sv
// Self-checking bench for host_mailbox: table-driven host vectors plus scoreboarded
// command/response sequences covering overflow, underflow, full push+pop and async reset.
module tb_host_mailbox;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 15;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 host_en;
  logic [3:0]           host_we;
  logic [ADDR_W-1:0]    host_addr;
  logic [31:0]          host_din;
  logic [31:0]          host_dout;
  logic                 host_rst;
  logic [NUM_CH-1:0]    cmd_valid;
  logic [NUM_CH*32-1:0] cmd_data;
  logic [NUM_CH-1:0]    cmd_ready;
  logic [NUM_CH-1:0]    rsp_valid;
  logic [NUM_CH*32-1:0] rsp_data;
  logic [NUM_CH-1:0]    rsp_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_rd [$];
  logic [31:0] exp_cmd[$];

  typedef struct {
    bit          rd;
    logic [14:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  host_mailbox #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
    .host_din(host_din), .host_dout(host_dout), .host_rst(host_rst),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [14:0] addr, input logic [3:0] we, input logic [31:0] din);
    @(negedge clk);
    host_en = 1'b1; host_we = we; host_addr = addr; host_din = din;
    @(posedge clk); #1;
    host_en = 1'b0; host_we = 4'h0;
  endtask

  // Read result is sampled after the following edge; host_dout holds until the next read.
  task automatic host_read(input string name, input logic [14:0] addr, input logic [31:0] exp);
    exp_rd.push_back(exp);
    @(negedge clk);
    host_en = 1'b1; host_we = 4'h0; host_addr = addr;
    @(posedge clk); #1;
    host_en = 1'b0;
    @(posedge clk); #1;
    check(name, host_dout, exp_rd.pop_front());
  endtask

  task automatic kernel_drain(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_ready[ch] = 1'b1;
      check("cmd_valid_drain", 32'(cmd_valid[ch]), 32'd1);
      check("cmd_data_drain", cmd_data[32*ch +: 32], exp_cmd.pop_front());
      @(posedge clk); #1;
    end
    cmd_ready[ch] = 1'b0;
  endtask

  task automatic kernel_push(input int ch, input logic [31:0] d);
    @(negedge clk);
    check("rsp_ready", 32'(rsp_ready[ch]), 32'd1);
    rsp_valid[ch] = 1'b1;
    rsp_data[32*ch +: 32] = d;
    @(posedge clk); #1;
    rsp_valid[ch] = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; host_en = 1'b0; host_we = 4'h0; host_addr = '0; host_din = '0;
    host_rst = 1'b0; cmd_ready = '0; rsp_valid = '0; rsp_data = '0;

    vecs[0]  = '{1'b0, 15'h10, 4'hF, 32'hCAFE_0001, 32'h0};
    vecs[1]  = '{1'b1, 15'h14, 4'h0, 32'h0,         32'h1};
    vecs[2]  = '{1'b0, 15'h40, 4'hF, 32'h0000_0001, 32'h0};
    vecs[3]  = '{1'b1, 15'h40, 4'h0, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 15'h04, 4'h0, 32'h0,         32'h0};
    vecs[5]  = '{1'b0, 15'h10, 4'h3, 32'h0000_0002, 32'h0};
    vecs[6]  = '{1'b1, 15'h14, 4'h0, 32'h0,         32'h1};
    vecs[7]  = '{1'b1, 15'h10, 4'h0, 32'h0,         32'h0};
    vecs[8]  = '{1'b0, 15'h1C, 4'hF, 32'h0000_0003, 32'h0};
    vecs[9]  = '{1'b1, 15'h1C, 4'h0, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 15'h14, 4'h0, 32'h0,         32'h1};
    vecs[11] = '{1'b1, 15'h48, 4'h0, 32'h0,         32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    check("rst_rsp_ready", 32'(rsp_ready), 32'hF);
    check("rst_host_dout", host_dout, 32'h0);
    @(negedge clk) rstn = 1'b1;

    // 1: three pushes to ch1, then drain in order
    host_write(15'h10, 4'hF, 32'h11); exp_cmd.push_back(32'h11);
    host_write(15'h10, 4'hF, 32'h22); exp_cmd.push_back(32'h22);
    host_write(15'h10, 4'hF, 32'h33); exp_cmd.push_back(32'h33);
    #1;
    check("t1_valid", 32'(cmd_valid[1]), 32'd1);
    check("t1_head", cmd_data[63:32], 32'h11);
    host_read("t1_status", 15'h14, 32'h3);
    kernel_drain(1, 3);
    check("t1_valid_drop", 32'(cmd_valid[1]), 32'd0);

    // 2: overflow ch0 and W1C the sticky
    for (int i = 0; i < 17; i++) begin
      host_write(15'h00, 4'hF, 32'h100 + 32'(i));
      if (i < DEPTH) exp_cmd.push_back(32'h100 + 32'(i));
    end
    host_read("t2_status_ovf", 15'h04, 32'h0001_0010);
    host_write(15'h04, 4'hF, 32'h0001_0000);
    host_read("t2_status_clr", 15'h04, 32'h0000_0010);
    kernel_drain(0, DEPTH);
    host_read("t2_status_empty", 15'h04, 32'h0);

    // 3: kernel responses on ch2, host pops, then underflow
    kernel_push(2, 32'hA5A5_0001);
    kernel_push(2, 32'hA5A5_0002);
    host_read("t3_status", 15'h24, 32'h0000_0200);
    host_read("t3_pop1", 15'h28, 32'hA5A5_0001);
    host_read("t3_pop2", 15'h28, 32'hA5A5_0002);
    host_read("t3_pop_empty", 15'h28, 32'h0);
    host_read("t3_status_udf", 15'h24, 32'h0002_0000);
    host_write(15'h24, 4'h4, 32'h0002_0000);
    host_read("t3_status_clr", 15'h24, 32'h0);

    // 4: full ch3, host push and kernel pop in one cycle
    for (int i = 0; i < DEPTH; i++) begin
      host_write(15'h30, 4'hF, 32'h300 + 32'(i));
      exp_cmd.push_back(32'h300 + 32'(i));
    end
    host_read("t4_status_full", 15'h34, 32'h0000_0010);
    @(negedge clk);
    host_en = 1'b1; host_we = 4'hF; host_addr = 15'h30; host_din = 32'hBEEF;
    cmd_ready[3] = 1'b1;
    check("t4_head", cmd_data[127:96], exp_cmd.pop_front());
    exp_cmd.push_back(32'hBEEF);
    @(posedge clk); #1;
    host_en = 1'b0; host_we = 4'h0; cmd_ready[3] = 1'b0;
    host_read("t4_status_same", 15'h34, 32'h0000_0010);
    kernel_drain(3, DEPTH);

    // 5: async reset mid-burst with a read pending
    for (int i = 0; i < 8; i++) host_write(15'h00, 4'hF, 32'h500 + 32'(i));
    kernel_push(1, 32'h5151_0001);
    kernel_push(1, 32'h5151_0002);
    host_read("t5_status_pre", 15'h04, 32'h8);
    @(negedge clk);
    host_en = 1'b1; host_we = 4'h0; host_addr = 15'h18;
    #2 rstn = 1'b0;
    #1;
    check("t5_cmd_valid", 32'(cmd_valid), 32'h0);
    check("t5_rsp_ready", 32'(rsp_ready), 32'hF);
    check("t5_host_dout", host_dout, 32'h0);
    host_en = 1'b0;
    @(negedge clk) rstn = 1'b1;
    exp_cmd.delete();
    for (int c = 0; c < NUM_CH; c++) host_read("t5_status_ch", 15'(c * 16 + 4), 32'h0);

    // 6: out-of-range window, partial writes, reserved registers
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rd) host_read($sformatf("t6_vec%0d", i), vecs[i].addr, vecs[i].exp);
      else            host_write(vecs[i].addr, vecs[i].we, vecs[i].din);
    end
    #1;
    check("t6_head", cmd_data[63:32], 32'hCAFE_0001);

    // host_rst clears FIFOs and stickies synchronously
    host_write(15'h00, 4'hF, 32'h77);
    host_read("hr_pre_status", 15'h08, 32'h0);
    @(negedge clk) host_rst = 1'b1;
    @(posedge clk); #1 host_rst = 1'b0;
    check("hr_cmd_valid", 32'(cmd_valid), 32'h0);
    host_read("hr_status_ch1", 15'h14, 32'h0);
    host_read("hr_status_ch2", 15'h24, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
